// File: rtl/turn_signal_conditioner_if.sv
// Lever/tick bundle between the raw switch pins, the conditioner and the sequencer.
// hazard_raw exists only when TURN_COND_HAZARD_EN is defined.
interface turn_signal_conditioner_if;
    logic left_raw;
    logic right_raw;
`ifdef TURN_COND_HAZARD_EN
    logic hazard_raw;
`endif
    logic left;
    logic right;
    logic tick;

`ifdef TURN_COND_HAZARD_EN
    modport master (output left_raw, right_raw, hazard_raw, input left, right, tick);
    modport slave  (input left_raw, right_raw, hazard_raw, output left, right, tick);
`else
    modport master (output left_raw, right_raw, input left, right, tick);
    modport slave  (input left_raw, right_raw, output left, right, tick);
`endif
endinterface

// File: rtl/turn_signal_conditioner.sv
// Synchronises and debounces the turn levers and generates the sequencer step tick.
// Optional hazard channel: define TURN_COND_HAZARD_EN.
module turn_signal_conditioner #(
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int unsigned DEBOUNCE_MS = 20,
    parameter int unsigned TICK_HZ     = 4
) (
    input logic                      clk,
    input logic                      reset,
    turn_signal_conditioner_if.slave tsc
);
    localparam int unsigned DB_CYCLES = CLK_HZ / 1000 * DEBOUNCE_MS;
    localparam int unsigned TICK_DIV  = CLK_HZ / TICK_HZ;
    localparam int unsigned CW        = $clog2(DB_CYCLES + 1);
    localparam int unsigned PW        = $clog2(TICK_DIV);
`ifdef TURN_COND_HAZARD_EN
    localparam int unsigned NCH       = 3;
`else
    localparam int unsigned NCH       = 2;
`endif
    localparam logic [CW-1:0] DB_LAST   = CW'(DB_CYCLES - 1);
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

    logic [NCH-1:0] w_raw;
    logic [NCH-1:0] w_stable_nxt;

`ifdef TURN_COND_HAZARD_EN
    assign w_raw = {tsc.hazard_raw, tsc.right_raw, tsc.left_raw};
`else
    assign w_raw = {tsc.right_raw, tsc.left_raw};
`endif

    // One synchroniser + debounce channel per raw switch.
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        logic          r_s1;
        logic          r_s2;
        logic          r_stable;
        logic [CW-1:0] r_cnt;
        logic          w_stable;
        logic [CW-1:0] w_cnt;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_s1     <= 1'b0;
                r_s2     <= 1'b0;
                r_stable <= 1'b0;
                r_cnt    <= '0;
            end else begin
                r_s1     <= w_raw[gi];
                r_s2     <= r_s1;
                r_stable <= w_stable;
                r_cnt    <= w_cnt;
            end
        end

        // Any sample matching the stable level restarts the window.
        always_comb begin
            w_stable = r_stable;
            w_cnt    = '0;
            if (r_s2 != r_stable) begin
                if (r_cnt == DB_LAST) begin
                    w_stable = r_s2;
                end else begin
                    w_cnt = r_cnt + CW'(1);
                end
            end
        end

        assign w_stable_nxt[gi] = w_stable;
    end

    logic          r_left;
    logic          r_right;
    logic          r_tick;
    logic [PW-1:0] r_presc;
    logic          w_left_nxt;
    logic          w_right_nxt;
    logic          w_restart;
    logic          w_tick_nxt;
    logic [PW-1:0] w_presc_nxt;

    // Output levels are built from next-state so they add no latency over the channels.
    always_comb begin
`ifdef TURN_COND_HAZARD_EN
        w_left_nxt  = w_stable_nxt[0] | w_stable_nxt[2];
        w_right_nxt = w_stable_nxt[1] | w_stable_nxt[2];
`else
        w_left_nxt  = w_stable_nxt[0];
        w_right_nxt = w_stable_nxt[1];
`endif
    end

    assign w_restart = (w_left_nxt | w_right_nxt) & ~(r_left | r_right);

    // Free-running prescaler, realigned when the outputs first become active.
    always_comb begin
        w_presc_nxt = r_presc + PW'(1);
        w_tick_nxt  = 1'b0;
        if (r_presc == TICK_LAST) begin
            w_presc_nxt = '0;
            w_tick_nxt  = 1'b1;
        end
        if (w_restart) begin
            w_presc_nxt = '0;
            w_tick_nxt  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_left  <= 1'b0;
            r_right <= 1'b0;
            r_tick  <= 1'b0;
            r_presc <= '0;
        end else begin
            r_left  <= w_left_nxt;
            r_right <= w_right_nxt;
            r_tick  <= w_tick_nxt;
            r_presc <= w_presc_nxt;
        end
    end

    assign tsc.left  = r_left;
    assign tsc.right = r_right;
    assign tsc.tick  = r_tick;
endmodule

// File: tb/tb_turn_signal_conditioner.sv
// Directed bench for turn_signal_conditioner with DB_CYCLES=4, TICK_DIV=4.
// Hazard scenario is included when TURN_COND_HAZARD_EN is defined.
module tb_turn_signal_conditioner;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    turn_signal_conditioner_if tsc_if ();

    turn_signal_conditioner #(
        .CLK_HZ      (1000),
        .DEBOUNCE_MS (4),
        .TICK_HZ     (250)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .tsc   (tsc_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bit i of each mask is the expected level just after the i-th edge of the run.
    task automatic run_seq(input string tag, input int n,
                           input logic [31:0] el, input logic [31:0] er, input logic [31:0] et);
        for (int i = 0; i < n; i++) begin
            step();
            chk($sformatf("%s.left@%0d", tag, i),  tsc_if.left,  el[i[4:0]]);
            chk($sformatf("%s.right@%0d", tag, i), tsc_if.right, er[i[4:0]]);
            chk($sformatf("%s.tick@%0d", tag, i),  tsc_if.tick,  et[i[4:0]]);
        end
    endtask

    initial begin
        logic [3:0] pat;
        pat = 4'b0101;

        // Reset held with every raw input high.
        tsc_if.left_raw  = 1'b1;
        tsc_if.right_raw = 1'b1;
`ifdef TURN_COND_HAZARD_EN
        tsc_if.hazard_raw = 1'b1;
`endif
        run_seq("rst", 3, 32'h0, 32'h0, 32'h0);

        // Release: first tick on the 4th edge, then every 4.
        tsc_if.left_raw  = 1'b0;
        tsc_if.right_raw = 1'b0;
`ifdef TURN_COND_HAZARD_EN
        tsc_if.hazard_raw = 1'b0;
`endif
        reset = 1'b1;
        run_seq("rel", 8, 32'h0, 32'h0, 32'h88);

        // Clean left press; rise at edge 5 restarts the prescaler.
        tsc_if.left_raw = 1'b1;
        run_seq("press", 10, 32'h3E0, 32'h0, 32'h208);
        tsc_if.left_raw = 1'b0;
        run_seq("unpress", 8, 32'h1F, 32'h0, 32'h88);

        // Right lever bounce 1,0,1,0 then held high.
        for (int i = 0; i < 4; i++) begin
            tsc_if.right_raw = pat[i];
            step();
            chk($sformatf("bounce.right@%0d", i), tsc_if.right, 1'b0);
            chk($sformatf("bounce.tick@%0d", i),  tsc_if.tick,  1'(i == 3));
        end
        tsc_if.right_raw = 1'b1;
        run_seq("settle", 10, 32'h0, 32'h3E0, 32'h208);
        tsc_if.right_raw = 1'b0;
        run_seq("unright", 8, 32'h0, 32'h1F, 32'h88);

        // Left rises with the prescaler at 2: next tick is 4 edges later, not 2.
        run_seq("idle", 1, 32'h0, 32'h0, 32'h0);
        tsc_if.left_raw = 1'b1;
        run_seq("restart", 10, 32'h3E0, 32'h0, 32'h204);
        // Right joining an active left must not restart.
        tsc_if.right_raw = 1'b1;
        run_seq("second", 10, 32'h3FF, 32'h3E0, 32'h88);

        // Line up so tick is high, then reset between edges.
        run_seq("pre", 2, 32'h3, 32'h3, 32'h2);
        reset = 1'b0;
        #1;
        chk("async.left",  tsc_if.left,  1'b0);
        chk("async.right", tsc_if.right, 1'b0);
        chk("async.tick",  tsc_if.tick,  1'b0);
        run_seq("held", 1, 32'h0, 32'h0, 32'h0);
        tsc_if.right_raw = 1'b0;
        reset = 1'b1;
        run_seq("rst_rel", 10, 32'h3E0, 32'h0, 32'h208);
        tsc_if.left_raw = 1'b0;
        run_seq("rst_unl", 8, 32'h1F, 32'h0, 32'h88);

`ifdef TURN_COND_HAZARD_EN
        // Hazard forces both outputs and restarts the prescaler.
        tsc_if.hazard_raw = 1'b1;
        run_seq("hazard", 10, 32'h3E0, 32'h3E0, 32'h208);
        tsc_if.hazard_raw = 1'b0;
        run_seq("unhazard", 8, 32'h1F, 32'h1F, 32'h88);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/turn_signal_conditioner.md
# turn_signal_conditioner

- Input stage placed directly upstream of the tail-light sequencer FSM.
- Takes the raw, asynchronous, bouncy `left_raw`/`right_raw` lever switches from the DE0-Nano pins.
- Synchronizes and debounces each input and presents clean `left`/`right` levels to the sequencer.
- Generates `tick`, the single-cycle step enable that paces the light sequence at a human-visible rate from the 50 MHz board clock.

## Interface
Parameters:
- `CLK_HZ`, default 50_000_000: input clock frequency in Hz.
- `DEBOUNCE_MS`, default 20: stability window. Derived `DB_CYCLES = CLK_HZ/1000*DEBOUNCE_MS`, must be ≥ 1.
- `TICK_HZ`, default 4: sequencer step rate. Derived `TICK_DIV = CLK_HZ/TICK_HZ`, must be ≥ 2.

Ports:
- `clk` in 1: single clock; all state on rising edge.
- `reset` in 1: asynchronous, active-low reset (0 = reset).
- `left_raw` in 1: raw left lever, asynchronous, may bounce.
- `right_raw` in 1: raw right lever, asynchronous, may bounce.
- `hazard_raw` in 1: raw hazard switch. Present only with `TURN_COND_HAZARD_EN`.
- `left` out 1: debounced left request, registered.
- `right` out 1: debounced right request, registered.
- `tick` out 1: one-cycle step-enable pulse, registered.

## Operation
Input path, per raw input:
- Two-flop synchronizer (`s1`, `s2`) feeds a debounce channel.
- Each channel holds a `stable` bit and a counter of width `$clog2(DB_CYCLES+1)`.

Debounce rules, evaluated every cycle:
- If `s2 != stable`:
  - counter < `DB_CYCLES-1`: counter increments.
  - counter = `DB_CYCLES-1`: `stable` takes `s2` and counter clears, on the same edge.
- If `s2 == stable`: counter clears. Any glitch shorter than `DB_CYCLES` samples is discarded entirely.

Outputs:
- `left` = left channel `stable`; `right` = right channel `stable`.
- Both may be 1 simultaneously; the sequencer interprets this case. No mutual exclusion is applied here.

Tick prescaler:
- Counter runs 0..`TICK_DIV-1` and wraps to 0.
- `tick` is registered to 1 for exactly the one cycle after the counter holds `TICK_DIV-1`.

Restart rule:
- Restart condition: registered `(left|right)` goes 0→1.
- On that edge the prescaler is forced to 0 and `tick` is 0.
- Result: the first step after activation is a full `TICK_DIV` cycles away.
- Both outputs rising on the same edge counts as a single restart.
- A second lever activating while the other is already active does not restart the prescaler.

## Timing
- Reset (asserted, async): `s1`, `s2`, `stable`, all counters, and the prescaler clear to 0 immediately.
  - Reset values: `left=0`, `right=0`, `tick=0`.
  - Holds while `reset=0`.
- Reset mid-debounce or mid-sequence: all in-progress counts are lost, with no residual pulse.
- Release: first evaluating edge is the first rising `clk` with `reset=1`. The prescaler starts from 0.
- Debounce latency: a raw change captured into `s1` at edge 0 appears on the output at edge `DB_CYCLES+1`, provided the input is held.
  - Same latency for rise and fall.
- `tick` period: exactly `TICK_DIV` cycles in steady state.
- `tick` is independent of the left/right levels except through the restart rule.

## Configuration
Macro: `TURN_COND_HAZARD_EN`.

Defined:
- Adds port `hazard_raw` with its own synchronizer and debounce channel, using the same rules and latency.
- While debounced hazard = 1: `left=1` and `right=1`, regardless of the levers.
- Hazard rising while `left|right` = 0 triggers the restart rule.

Undefined:
- Port and logic are absent; outputs follow the levers only.

## Test plan
Parameters for all scenarios: `CLK_HZ=1000`, `DEBOUNCE_MS=4`, `TICK_HZ=250`, giving `DB_CYCLES=4` and `TICK_DIV=4`.

1. Reset: drive `reset=0` with all raw inputs 1 for 3 cycles → `left=right=tick=0` throughout. Release → first `tick` occurs 4 cycles after release.
2. Clean press: `left_raw` 0→1 captured at edge 0 and held → `left` rises at edge 5 and `right` stays 0. Release → `left` falls 5 edges after the release is captured.
3. Bounce: `right_raw` toggles 1,0,1,0 (one cycle each), then holds 1 → `right` never pulses during the bounce and rises 5 edges after the final 0→1 capture.
4. Restart: while the prescaler is at 2, `left` rises → prescaler forced to 0, and the next `tick` comes 4 cycles later, not 2. `right` rising later does not restart.
5. Reset mid-operation: with `left=1`, assert `reset` between clock edges → `left` and `tick` drop to 0 immediately, before the next edge. After release with `left_raw` still 1 → `left` rises at edge 5.
6. With `TURN_COND_HAZARD_EN` defined: `hazard_raw=1` held while both levers are 0 → both `left` and `right` rise at edge 5 and the prescaler restarts. Without the macro, the port is absent and scenarios 1–5 pass unchanged.
